// File: rtl/nf_router_pkg.sv
// Shared definitions for the load/store router response path.
// Contents:
//   nf_rresp_st_t    - response FSM state encoding
//   NF_BUS_ERR_WORD  - read data returned to the master on a bus error
//   NF_SLV_*         - slave port index assignments on the router
//   NF_SLAVE_NUMBER  - default number of slave ports
package nf_router_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2,
    ERR      = 2'd3
  } nf_rresp_st_t;

  localparam logic [31:0] NF_BUS_ERR_WORD = 32'hDEAD_BEEF;

  localparam int NF_SLV_RAM  = 0;
  localparam int NF_SLV_GPIO = 1;
  localparam int NF_SLV_PWM  = 2;

  localparam int NF_SLAVE_NUMBER = 4;

endpackage

// File: rtl/nf_onehot2idx.sv
// One-hot to binary index converter.
// Ports:
//   onehot     in   N    one-hot select vector
//   idx        out  IW   index of the set bit (meaningful only when onehot_ok)
//   onehot_ok  out  1    exactly one bit of onehot is set
module nf_onehot2idx #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          onehot_ok
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
    // Non-zero and clearing the lowest set bit leaves nothing behind.
    onehot_ok = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);
  end

endmodule

// File: rtl/nf_router_resp.sv
// Return path of the load/store router (slave -> master). Tracks a single
// outstanding load or store, forwards the selected slave's acknowledge to the
// master, captures load data, times out on a hung slave and reports a bus
// error for unmapped or multiply-decoded addresses.
// Ports:
//   clk         in   1           system clock, rising edge
//   resetn      in   1           asynchronous active-low reset
//   req_m       in   1           master request, held until req_ack_m
//   we_m        in   1           1 = store, 0 = load
//   slave_sel   in   Slave_n     one-hot slave select from the address decoder
//   req_ack_s   in   Slave_n     per-slave request acknowledge
//   rd_s        in   Slave_n*32  per-slave read data, slave i at [32*i +: 32]
//   req_ack_m   out  1           acknowledge to master (combinational)
//   rd_m        out  32          registered read data to master
//   rd_valid_m  out  1           one-cycle pulse: rd_m updated
//   bus_err     out  1           one-cycle pulse: transaction aborted
module nf_router_resp
  import nf_router_pkg::*;
#(
  parameter int          Slave_n  = NF_SLAVE_NUMBER,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_WORD = NF_BUS_ERR_WORD
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_m,
  input  logic                 we_m,
  input  logic [Slave_n-1:0]   slave_sel,
  input  logic [Slave_n-1:0]   req_ack_s,
  input  logic [Slave_n*32-1:0] rd_s,
  output logic                 req_ack_m,
  output logic [31:0]          rd_m,
  output logic                 rd_valid_m,
  output logic                 bus_err
);

  localparam int IW = (Slave_n > 1) ? $clog2(Slave_n) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  nf_rresp_st_t       state_q, state_d;
  logic [Slave_n-1:0] sel_q, sel_d;
  logic               we_q, we_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [31:0]        rd_m_q, rd_m_d;
  logic               rd_valid_q, rd_valid_d;
  logic               bus_err_q, bus_err_d;

  logic [IW-1:0]      in_idx;
  logic               in_ok;
  logic [IW-1:0]      sel_idx;
  logic               sel_ok;
  logic               ack_hit;

  // Decoder select is validated as it arrives; the latched select is
  // converted again to pick the read-data lane in RESP.
  nf_onehot2idx #(.N(Slave_n), .IW(IW)) u_in_dec (
    .onehot    (slave_sel),
    .idx       (in_idx),
    .onehot_ok (in_ok)
  );

  nf_onehot2idx #(.N(Slave_n), .IW(IW)) u_sel_dec (
    .onehot    (sel_q),
    .idx       (sel_idx),
    .onehot_ok (sel_ok)
  );

  // Only the slave that was actually addressed may complete the transaction.
  assign ack_hit = |(req_ack_s & sel_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    tmo_cnt_d  = tmo_cnt_q;
    rd_m_d     = rd_m_q;
    rd_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    req_ack_m  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_m) begin
          // Direction is kept even on a decode error: it decides whether
          // the error also returns ERR_WORD as load data.
          we_d = we_m;
          if (in_ok) begin
            sel_d     = slave_sel;
            tmo_cnt_d = '0;
            state_d   = WAIT_ACK;
          end else begin
            sel_d   = '0;
            state_d = ERR;
          end
        end
      end

      WAIT_ACK: begin
        req_ack_m = ack_hit;
        if (ack_hit) begin
          // An ack on the final allowed cycle still completes normally.
          state_d = we_q ? IDLE : RESP;
        end else begin
          if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TW'(1);
          if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) state_d = ERR;
        end
      end

      RESP: begin
        // The slave presents its data the cycle after acknowledging.
        if (sel_ok) rd_m_d = rd_s[int'(sel_idx) * 32 +: 32];
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end

      ERR: begin
        req_ack_m = 1'b1;
        bus_err_d = 1'b1;
        if (!we_q) begin
          rd_m_d     = ERR_WORD;
          rd_valid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Silence the unused decoded index of the incoming select.
    if (in_idx == '0) begin end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      tmo_cnt_q  <= '0;
      rd_m_q     <= '0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rd_m_q     <= rd_m_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign rd_m       = rd_m_q;
  assign rd_valid_m = rd_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_nf_router_resp.sv
// Bench for nf_router_resp with four slaves and TIMEOUT = 4.
module tb_nf_router_resp;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            req_m;
  logic            we_m;
  logic [NS-1:0]   slave_sel;
  logic [NS-1:0]   req_ack_s;
  logic [NS*32-1:0] rd_s;
  logic            req_ack_m;
  logic [31:0]     rd_m;
  logic            rd_valid_m;
  logic            bus_err;

  nf_router_resp #(.Slave_n(NS), .TIMEOUT(4), .ERR_WORD(32'hDEAD_BEEF)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_m      (req_m),
    .we_m       (we_m),
    .slave_sel  (slave_sel),
    .req_ack_s  (req_ack_s),
    .rd_s       (rd_s),
    .req_ack_m  (req_ack_m),
    .rd_m       (rd_m),
    .rd_valid_m (rd_valid_m),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  stray;
    int          d;       // WAIT_ACK cycle index of the slave ack (99 = never)
    logic [31:0] rdata;
    int          exp_k;   // cycles after request until req_ack_m
    logic        exp_err;
    logic        exp_rdv;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        rdv;
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[10];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  logic [31:0] model_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input string nm, input logic we, input logic [3:0] sel,
                              input logic [3:0] stray, input int d, input logic [31:0] rdata,
                              input int k, input logic err, input logic rdv,
                              input logic [31:0] rd);
    vec_t v;
    v.name = nm; v.we = we; v.sel = sel; v.stray = stray; v.d = d; v.rdata = rdata;
    v.exp_k = k; v.exp_err = err; v.exp_rdv = rdv; v.exp_rd = rd;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (req_ack_m) ack_cnt++;
    if (rd_valid_m || bus_err) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rd_valid_m, bus_err}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_rd_valid", {31'd0, rd_valid_m}, {31'd0, e.rdv});
        chk("out_bus_err", {31'd0, bus_err}, {31'd0, e.err});
        chk("out_cycle", cyc, e.cyc);
        if (e.rdv) chk("out_rd_m", rd_m, e.rd);
      end
    end
  end

  task automatic drive_rd(input logic [3:0] sel, input logic [31:0] data, input bit real_data);
    for (int i = 0; i < NS; i++)
      rd_s[32*i +: 32] = (real_data && sel[i]) ? data : (32'h0BAD_0000 + 32'(i));
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int ack_cyc;
    bit got;
    ack_cnt   = 0;
    req_m     = 1'b1;
    we_m      = v.we;
    slave_sel = v.sel;
    req_ack_s = '0;
    k   = 0;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ack_m) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
      if (k - 1 == v.d)     req_ack_s = v.sel;
      else if (k - 1 < v.d) req_ack_s = v.stray;
      else                  req_ack_s = '0;
    end
    ack_cyc = cyc;
    chk({v.name, "_ack_seen"}, {31'd0, got}, 32'd1);
    chk({v.name, "_ack_cycle"}, k, v.exp_k);
    if (v.exp_rdv || v.exp_err)
      sbq.push_back('{rdv: v.exp_rdv, err: v.exp_err, rd: v.exp_rd,
                      cyc: ack_cyc + (v.exp_err ? 1 : 2)});
    if (v.exp_rdv) model_rd = v.exp_rd;
    @(posedge clk); #1;
    req_m     = 1'b0;
    req_ack_s = '0;
    drive_rd(v.sel, v.rdata, 1'b1);
    @(posedge clk); #1;
    drive_rd(v.sel, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk({v.name, "_ack_count"}, ack_cnt, 32'd1);
    chk({v.name, "_rd_m_hold"}, rd_m, model_rd);
  endtask

  initial begin
    vecs[0] = mk("load_ram",    1'b0, 4'b0001, 4'b0000, 0,  32'h1234_5678, 1, 1'b0, 1'b1, 32'h1234_5678);
    vecs[1] = mk("store_gpio",  1'b1, 4'b0010, 4'b0000, 3,  32'h0000_0000, 4, 1'b0, 1'b0, 32'h0000_0000);
    vecs[2] = mk("unmapped",    1'b0, 4'b0000, 4'b0000, 99, 32'h0000_0000, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    vecs[3] = mk("multi_dec",   1'b0, 4'b0011, 4'b0000, 99, 32'h0000_0000, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    vecs[4] = mk("st_unmapped", 1'b1, 4'b0000, 4'b0000, 99, 32'h0000_0000, 1, 1'b1, 1'b0, 32'h0000_0000);
    vecs[5] = mk("timeout",     1'b0, 4'b0100, 4'b0000, 99, 32'h0000_0000, 5, 1'b1, 1'b1, 32'hDEAD_BEEF);
    vecs[6] = mk("ack_last",    1'b0, 4'b0100, 4'b0000, 3,  32'hCAFE_0001, 4, 1'b0, 1'b1, 32'hCAFE_0001);
    vecs[7] = mk("stray_ack",   1'b0, 4'b0001, 4'b0010, 2,  32'hAAAA_5555, 3, 1'b0, 1'b1, 32'hAAAA_5555);
    vecs[8] = mk("st_timeout",  1'b1, 4'b1000, 4'b0000, 99, 32'h0000_0000, 5, 1'b1, 1'b0, 32'h0000_0000);
    vecs[9] = mk("load_pwm",    1'b0, 4'b0100, 4'b0000, 1,  32'h0BAD_F00D, 2, 1'b0, 1'b1, 32'h0BAD_F00D);

    resetn    = 1'b0;
    req_m     = 1'b0;
    we_m      = 1'b0;
    slave_sel = '0;
    req_ack_s = '0;
    drive_rd(4'b0000, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ack_m", {31'd0, req_ack_m}, 32'd0);
    chk("rst_rd_m", rd_m, 32'd0);
    chk("rst_rd_valid_m", {31'd0, rd_valid_m}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of WAIT_ACK while the slave is acknowledging.
    ack_cnt   = 0;
    req_m     = 1'b1;
    we_m      = 1'b0;
    slave_sel = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_ack_s = 4'b0001;
    #1;
    chk("midrst_ack_before", {31'd0, req_ack_m}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_req_ack_m", {31'd0, req_ack_m}, 32'd0);
    chk("midrst_rd_m", rd_m, 32'd0);
    chk("midrst_rd_valid_m", {31'd0, rd_valid_m}, 32'd0);
    chk("midrst_bus_err", {31'd0, bus_err}, 32'd0);
    req_ack_s = '0;
    req_m     = 1'b0;
    @(posedge clk); #1;
    resetn   = 1'b1;
    model_rd = '0;
    ack_cnt  = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_ack", ack_cnt, 32'd0);
    chk("midrst_rd_m_after", rd_m, 32'd0);

    run_vec(vecs[9]);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
